// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-cache controller for the pipelined LC-3b core.
module mem_access_unit #(
  parameter logic [3:0] OP_LDB = 4'b0010,
  parameter logic [3:0] OP_LDR = 4'b0110,
  parameter logic [3:0] OP_LDI = 4'b1010,
  parameter logic [3:0] OP_STB = 4'b0011,
  parameter logic [3:0] OP_STR = 4'b0111,
  parameter logic [3:0] OP_STI = 4'b1011
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [3:0]  operation_in,
  input  logic [15:0] alu_out_in,
  input  logic [15:0] store_data_in,
  input  logic [2:0]  dest_in,
  input  logic        load_regfile_in,
  input  logic        ext_stall_in,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] regfilemux_out,
  output logic [2:0]  dest_out,
  output logic        load_regfile_out,
  output logic        stall_pipeline
);

  typedef enum logic [1:0] {IDLE, INDIR, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] result_q, result_d;

  logic is_ldb, is_ldr, is_ldi, is_stb, is_str, is_sti;
  logic is_load, is_indirect, mem_op;
  logic [7:0]  byte_sel;
  logic [15:0] load_data, final_value;
  logic        rd, wr, mem_stall;

  assign is_ldb      = (operation_in == OP_LDB);
  assign is_ldr      = (operation_in == OP_LDR);
  assign is_ldi      = (operation_in == OP_LDI);
  assign is_stb      = (operation_in == OP_STB);
  assign is_str      = (operation_in == OP_STR);
  assign is_sti      = (operation_in == OP_STI);
  assign is_load     = is_ldb | is_ldr | is_ldi;
  assign is_indirect = is_ldi | is_sti;
  assign mem_op      = valid_in & (is_load | is_stb | is_str | is_sti);

  assign byte_sel    = alu_out_in[0] ? mem_rdata[15:8] : mem_rdata[7:0];
  assign load_data   = is_ldb ? {{8{byte_sel[7]}}, byte_sel} : mem_rdata;
  assign final_value = is_load ? load_data : alu_out_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    result_d        = result_q;
    mem_address     = alu_out_in & 16'hFFFE;
    mem_wdata       = store_data_in;
    mem_byte_enable = 2'b11;
    rd              = 1'b0;
    wr              = 1'b0;
    regfilemux_out  = alu_out_in;
    mem_stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          rd = is_load | is_sti;
          wr = is_str | is_stb;
          if (is_stb) begin
            mem_address     = alu_out_in;
            mem_wdata       = {store_data_in[7:0], store_data_in[7:0]};
            mem_byte_enable = alu_out_in[0] ? 2'b10 : 2'b01;
          end else if (is_ldb) begin
            mem_address = alu_out_in;
          end
          if (mem_resp) begin
            if (is_indirect) begin
              // Pointer fetched; the second access starts next cycle with no gap.
              ptr_d     = mem_rdata;
              state_d   = INDIR;
              mem_stall = 1'b1;
            end else begin
              regfilemux_out = final_value;
              if (ext_stall_in) begin
                result_d = final_value;
                state_d  = HOLD;
              end
            end
          end else begin
            mem_stall = 1'b1;
          end
        end
      end
      INDIR: begin
        mem_address = ptr_q & 16'hFFFE;
        rd          = is_ldi;
        wr          = ~is_ldi;
        if (mem_resp) begin
          regfilemux_out = final_value;
          if (ext_stall_in) begin
            result_d = final_value;
            state_d  = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          mem_stall = 1'b1;
        end
      end
      HOLD: begin
        // Instruction is frozen in EX/MEM; replay the captured value instead of re-accessing.
        regfilemux_out = result_q;
        if (!ext_stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read         = rd & reset_n;
  assign mem_write        = wr & reset_n;
  assign stall_pipeline   = (mem_stall & reset_n) | ext_stall_in;
  assign dest_out         = dest_in;
  assign load_regfile_out = load_regfile_in & valid_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table and sequence bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [3:0]  operation_in;
  logic [15:0] alu_out_in;
  logic [15:0] store_data_in;
  logic [2:0]  dest_in;
  logic        load_regfile_in;
  logic        ext_stall_in;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] regfilemux_out;
  logic [2:0]  dest_out;
  logic        load_regfile_out;
  logic        stall_pipeline;

  localparam logic [3:0] ADD = 4'b0001, LDB = 4'b0010, LDR = 4'b0110, LDI = 4'b1010;
  localparam logic [3:0] STB = 4'b0011, STR = 4'b0111, STI = 4'b1011;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .operation_in(operation_in),
    .alu_out_in(alu_out_in), .store_data_in(store_data_in), .dest_in(dest_in),
    .load_regfile_in(load_regfile_in), .ext_stall_in(ext_stall_in), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .regfilemux_out(regfilemux_out), .dest_out(dest_out), .load_regfile_out(load_regfile_out),
    .stall_pipeline(stall_pipeline)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] alu;
    logic [15:0] sr;
    logic        ldrf;
    logic        resp;
    logic [15:0] rdata;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_rd;
    logic        e_wr;
    logic [1:0]  e_be;
    logic [15:0] e_rmux;
    logic        e_stall;
    logic        e_ldrf;
  } vec_t;

  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                       input logic [15:0] sr, input logic ext, input logic resp,
                       input logic [15:0] rdata);
    valid_in      = v;
    operation_in  = op;
    alu_out_in    = alu;
    store_data_in = sr;
    ext_stall_in  = ext;
    mem_resp      = resp;
    mem_rdata     = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int reads;
    int stalls;

    vecs[0] = '{1'b1, ADD, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b11, 16'h1234, 1'b0, 1'b1};
    vecs[1] = '{1'b0, LDR, 16'h1000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b11, 16'h1000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, LDR, 16'h1003, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 16'h1002, 16'h0000, 1'b1, 1'b0, 2'b11, 16'hA5A5, 1'b0, 1'b1};
    vecs[3] = '{1'b1, LDB, 16'h2001, 16'h0000, 1'b1, 1'b1, 16'h80AA, 16'h2001, 16'h0000, 1'b1, 1'b0, 2'b11, 16'hFF80, 1'b0, 1'b1};
    vecs[4] = '{1'b1, LDB, 16'h2000, 16'h0000, 1'b1, 1'b1, 16'h80AA, 16'h2000, 16'h0000, 1'b1, 1'b0, 2'b11, 16'hFFAA, 1'b0, 1'b1};
    vecs[5] = '{1'b1, LDB, 16'h2000, 16'h0000, 1'b1, 1'b1, 16'h127F, 16'h2000, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h007F, 1'b0, 1'b1};
    vecs[6] = '{1'b1, STB, 16'h2001, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'h2001, 16'h3434, 1'b0, 1'b1, 2'b10, 16'h2001, 1'b0, 1'b0};
    vecs[7] = '{1'b1, STB, 16'h2000, 16'h00AB, 1'b0, 1'b1, 16'h0000, 16'h2000, 16'hABAB, 1'b0, 1'b1, 2'b01, 16'h2000, 1'b0, 1'b0};
    vecs[8] = '{1'b1, STR, 16'h2005, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h2004, 16'hBEEF, 1'b0, 1'b1, 2'b11, 16'h2005, 1'b0, 1'b0};

    reset_n = 1'b0;
    dest_in = 3'd5;
    load_regfile_in = 1'b1;
    drive(1'b1, LDR, 16'h1000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("reset read", 16'(mem_read), 16'h0);
    check("reset stall", 16'(stall_pipeline), 16'h0);
    drive(1'b0, ADD, 16'h0042, 16'h0000, 1'b0, 1'b0, 16'h0000);
    next_cycle();
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].alu, vecs[i].sr, 1'b0, vecs[i].resp, vecs[i].rdata);
      load_regfile_in = vecs[i].ldrf;
      @(negedge clk);
      check($sformatf("v%0d read", i), 16'(mem_read), 16'(vecs[i].e_rd));
      check($sformatf("v%0d write", i), 16'(mem_write), 16'(vecs[i].e_wr));
      check($sformatf("v%0d rmux", i), regfilemux_out, vecs[i].e_rmux);
      check($sformatf("v%0d stall", i), 16'(stall_pipeline), 16'(vecs[i].e_stall));
      check($sformatf("v%0d ldrf", i), 16'(load_regfile_out), 16'(vecs[i].e_ldrf));
      check($sformatf("v%0d dest", i), 16'(dest_out), 16'd5);
      if (vecs[i].e_rd || vecs[i].e_wr)
        check($sformatf("v%0d addr", i), mem_address, vecs[i].e_addr);
      if (vecs[i].e_wr) begin
        check($sformatf("v%0d wdata", i), mem_wdata, vecs[i].e_wdata);
        check($sformatf("v%0d be", i), 16'(mem_byte_enable), 16'(vecs[i].e_be));
      end
      next_cycle();
    end
    load_regfile_in = 1'b1;

    // LDR with 3-cycle cache latency
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, LDR, 16'h1001, 16'h0000, 1'b0, (c == 3), 16'hBEEF);
      @(negedge clk);
      check("ldr addr", mem_address, 16'h1000);
      check("ldr read", 16'(mem_read), 16'h1);
      if (stall_pipeline) stalls++;
      if (c == 3) check("ldr rmux", regfilemux_out, 16'hBEEF);
      next_cycle();
    end
    check("ldr stall cycles", 16'(stalls), 16'd3);
    drive(1'b0, ADD, 16'h0007, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("ldr idle read", 16'(mem_read), 16'h0);
    check("ldr idle rmux", regfilemux_out, 16'h0007);
    next_cycle();

    // LDI: pointer read, then data read with continuous stall
    drive(1'b1, LDI, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("ldi a1 addr", mem_address, 16'h3000);
    check("ldi a1 stall", 16'(stall_pipeline), 16'h1);
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 16'h4001;
    @(negedge clk);
    check("ldi a1 resp stall", 16'(stall_pipeline), 16'h1);
    next_cycle();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    check("ldi a2 addr", mem_address, 16'h4000);
    check("ldi a2 read", 16'(mem_read), 16'h1);
    check("ldi a2 stall", 16'(stall_pipeline), 16'h1);
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    check("ldi rmux", regfilemux_out, 16'h5555);
    check("ldi final stall", 16'(stall_pipeline), 16'h0);
    next_cycle();

    // STI: pointer read then word write
    drive(1'b1, STI, 16'h3000, 16'hCAFE, 1'b0, 1'b1, 16'h6000);
    @(negedge clk);
    check("sti a1 read", 16'(mem_read), 16'h1);
    check("sti a1 write", 16'(mem_write), 16'h0);
    check("sti a1 stall", 16'(stall_pipeline), 16'h1);
    next_cycle();
    mem_resp = 1'b0;
    @(negedge clk);
    check("sti a2 write", 16'(mem_write), 16'h1);
    check("sti a2 read", 16'(mem_read), 16'h0);
    check("sti a2 addr", mem_address, 16'h6000);
    check("sti a2 wdata", mem_wdata, 16'hCAFE);
    check("sti a2 be", 16'(mem_byte_enable), 16'h3);
    next_cycle();
    mem_resp = 1'b1;
    @(negedge clk);
    check("sti final stall", 16'(stall_pipeline), 16'h0);
    check("sti rmux", regfilemux_out, 16'h3000);
    next_cycle();

    // LDR completing under external stall -> HOLD
    reads = 0;
    drive(1'b1, LDR, 16'h1000, 16'h0000, 1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    if (mem_read) reads++;
    check("hold first rmux", regfilemux_out, 16'h1234);
    check("hold first stall", 16'(stall_pipeline), 16'h1);
    next_cycle();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_read) reads++;
      check("hold rmux", regfilemux_out, 16'h1234);
      next_cycle();
    end
    ext_stall_in = 1'b0;
    @(negedge clk);
    if (mem_read) reads++;
    check("hold release rmux", regfilemux_out, 16'h1234);
    check("hold release stall", 16'(stall_pipeline), 16'h0);
    check("hold read bursts", 16'(reads), 16'd1);
    next_cycle();
    drive(1'b0, ADD, 16'h0099, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("post hold rmux", regfilemux_out, 16'h0099);
    next_cycle();

    // Reset during INDIR of LDI
    drive(1'b1, LDI, 16'h3000, 16'h0000, 1'b0, 1'b1, 16'h4001);
    next_cycle();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    check("rst indir addr", mem_address, 16'h4000);
    #1 reset_n = 1'b0;
    #1;
    check("rst read drop", 16'(mem_read), 16'h0);
    check("rst stall drop", 16'(stall_pipeline), 16'h0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst reissue addr", mem_address, 16'h3000);
    check("rst reissue read", 16'(mem_read), 16'h1);
    check("rst reissue stall", 16'(stall_pipeline), 16'h1);
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 16'h4001;
    next_cycle();
    mem_rdata = 16'h7777;
    @(negedge clk);
    check("rst ldi rmux", regfilemux_out, 16'h7777);
    next_cycle();
    drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage memory controller of the pipelined LC-3b core. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Executes LDR/LDB/LDI/STR/STB/STI against the data-cache port, including two-access indirection for LDI/STI.
- Formats load data and produces the writeback value, destination and load_regfile consumed by MEM/WB.
- Raises the global stall_pipeline while a data access is outstanding.

Parameters:
- OP_LDB, 4'b0010, LDB opcode
- OP_LDR, 4'b0110, LDR opcode
- OP_LDI, 4'b1010, LDI opcode
- OP_STB, 4'b0011, STB opcode
- OP_STR, 4'b0111, STR opcode
- OP_STI, 4'b1011, STI opcode

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  EX/MEM holds a live instruction
- operation_in  in  4  lc3b_opcode from EX/MEM
- alu_out_in  in  16  effective address, or ALU result for non-memory ops
- store_data_in  in  16  SR value for stores
- dest_in  in  3  destination register
- load_regfile_in  in  1  instruction writes the register file
- ext_stall_in  in  1  stall request from the fetch side (i-cache miss)
- mem_resp  in  1  data-cache access complete
- mem_rdata  in  16  data-cache read data
- mem_address  out  16  data-cache address
- mem_wdata  out  16  data-cache write data
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_byte_enable  out  2  write byte mask
- regfilemux_out  out  16  writeback value to MEM/WB
- dest_out  out  3  to MEM/WB
- load_regfile_out  out  1  to MEM/WB
- stall_pipeline  out  1  global pipeline freeze (mem stall OR ext_stall_in)

Behaviour:
- States: IDLE, INDIR, HOLD. Registers: ptr (16), result (16).
- mem_op = valid_in and operation_in is one of the six opcodes above.
- Word accesses force address bit 0 to 0.
- Byte lane: LDB result = SEXT(addr[0] ? rdata[15:8] : rdata[7:0]). STB drives wdata = {sr[7:0], sr[7:0]} and byte_enable = addr[0] ? 2'b10 : 2'b01. Word accesses use byte_enable 2'b11.
- Reset (async, any state, including mid-access): state=IDLE, ptr=0, result=0. mem_read, mem_write and mem_stall are forced 0 while reset_n is low. After reset, a pending mem_op is re-issued from scratch.
- IDLE, non-mem op or valid_in=0: no strobes; regfilemux_out=alu_out_in; mem_stall=0; zero added latency.
- IDLE, mem_op: address = alu_out_in.
  - mem_read=1 for LDR/LDB/LDI/STI (first access of STI is a pointer read).
  - mem_write=1 for STR/STB.
  - Strobes stay asserted, combinationally, until mem_resp.
- On mem_resp in IDLE:
  - LDI/STI: ptr <= mem_rdata, go to INDIR; mem_stall stays 1.
  - Otherwise: the access is final.
- INDIR: address = {ptr[15:1], 1'b0}. LDI reads; STI writes store_data_in with byte_enable 2'b11. On mem_resp the access is final.
- Final access:
  - mem_stall=0 that cycle; regfilemux_out = formatted rdata for loads, alu_out_in for stores.
  - If ext_stall_in=1: result <= that value, go to HOLD.
  - Else: return to IDLE.
- HOLD: no strobes; regfilemux_out=result; mem_stall=0. Leave to IDLE on the first cycle with ext_stall_in=0. No access is re-issued while the same instruction is held in EX/MEM.
- mem_stall is 1 in IDLE (mem_op, no resp) and in INDIR (no resp).
- stall_pipeline = mem_stall | ext_stall_in.
- dest_out = dest_in and load_regfile_out = load_regfile_in & valid_in, in all states.
- mem_resp outside an issued strobe is ignored.
- Latency from strobe issue:
  - Direct ops: stall cycles = cache latency.
  - Indirect ops: sum of both access latencies; no dead cycle between the two accesses.

Test Plan:
- LDR, addr 0x1001, cache returns 0xBEEF after 3 cycles -> mem_address=0x1000, stall high 3 cycles, regfilemux_out=0xBEEF on resp cycle, then IDLE.
- LDB addr 0x2001, rdata 0x80AA -> regfilemux_out=0xFF80; LDB addr 0x2000 same data -> 0xFFAA; STB addr 0x2001, sr 0x1234 -> wdata 0x3434, byte_enable 2'b10.
- LDI addr 0x3000, first rdata 0x4001, second rdata 0x5555 -> second mem_address=0x4000, stall continuous across both accesses, regfilemux_out=0x5555.
- STI addr 0x3000 -> pointer 0x6000, sr 0xCAFE -> read then write to 0x6000 with wdata 0xCAFE, byte_enable 2'b11.
- LDR completes while ext_stall_in=1 for 4 more cycles -> HOLD, exactly one mem_read burst, regfilemux_out holds the loaded value, IDLE when ext_stall_in drops.
- reset_n low during INDIR of LDI -> strobes drop immediately, state IDLE, result/ptr=0; after release the LDI re-issues the first read at the original address.
